// File: rtl/mips_muldiv.sv
// mips_muldiv -- iterative multiply/divide unit holding the architectural
// HI/LO registers.
//
// A MULT/MULTU/DIV/DIVU issued with start runs one radix-2 step per cycle for
// WIDTH cycles. It then spends one fix-up cycle applying signs and writing
// HI/LO, so the result appears WIDTH+1 cycles after the start edge.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    issue a mult/div op (accepted only when idle)
//   md_op    00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   rs_data  multiplicand / dividend, or MTHI/MTLO write data
//   rt_data  multiplier / divisor
//   mthi     write rs_data to HI (idle, no start)
//   mtlo     write rs_data to LO (idle, no start)
//   hi, lo   architectural HI/LO registers
//   busy     operation in flight
//   done     one-cycle pulse when hi/lo carry a new result
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic                 div_reg;      // 1: divide, 0: multiply
  logic                 sgn_reg;      // signed op
  logic                 neg_q_reg;    // product/quotient must be negated
  logic                 neg_r_reg;    // remainder must be negated
  logic [WIDTH-1:0]     opnd_reg;     // |multiplicand| or |divisor|
  logic [WIDTH-1:0]     rs_reg;       // raw rs, returned in HI on divide-by-zero
  logic [2*WIDTH-1:0]   acc_reg;      // mult: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [WIDTH-1:0]     hi_reg, lo_reg;
  logic                 done_reg;

  logic                 load_en, step_en, fix_en;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy    = 1'b0;
    load_en = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    case (state_reg)
      IDLE:    load_en = start;
      RUN:     begin busy = 1'b1; step_en = 1'b1; end
      FIX:     begin busy = 1'b1; fix_en  = 1'b1; end
      default: ;
    endcase
  end

  // Operand conditioning at issue: signed ops work on magnitudes.
  // Negation wraps, so the most negative value stays as an unsigned magnitude.
  logic             op_signed;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  assign op_signed = ~md_op[0];
  assign rs_abs    = (op_signed && rs_data[WIDTH-1]) ? ('0 - rs_data) : rs_data;
  assign rt_abs    = (op_signed && rt_data[WIDTH-1]) ? ('0 - rt_data) : rt_data;

  // One iteration step
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] step_acc;

  assign mul_addend = acc_reg[0] ? opnd_reg : '0;
  assign mul_sum    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  // Restoring divide: shift the next dividend bit into the remainder and
  // keep the trial subtraction only when it does not go negative.
  assign div_shift  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, opnd_reg};

  always_comb begin
    if (!div_reg)
      step_acc = {mul_sum, acc_reg[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      step_acc = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    else
      step_acc = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
  end

  // Final sign fix-up and result mapping
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  assign prod_neg = '0 - acc_reg;

  always_comb begin
    fix_hi = acc_reg[2*WIDTH-1:WIDTH];
    fix_lo = acc_reg[WIDTH-1:0];
    if (!div_reg) begin
      if (sgn_reg && neg_q_reg) {fix_hi, fix_lo} = prod_neg;
    end else if (opnd_reg == '0) begin
      // Divide by zero: fixed, sign-independent result
      fix_hi = rs_reg;
      fix_lo = '1;
    end else begin
      if (sgn_reg && neg_q_reg) fix_lo = '0 - acc_reg[WIDTH-1:0];
      if (sgn_reg && neg_r_reg) fix_hi = '0 - acc_reg[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      div_reg   <= 1'b0;
      sgn_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      opnd_reg  <= '0;
      rs_reg    <= '0;
      acc_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load_en) begin
        cnt_reg   <= CW'(WIDTH - 1);
        div_reg   <= md_op[1];
        sgn_reg   <= op_signed;
        neg_q_reg <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
        neg_r_reg <= op_signed & rs_data[WIDTH-1];
        rs_reg    <= rs_data;
        if (md_op[1]) begin
          opnd_reg <= rt_abs;
          acc_reg  <= {{WIDTH{1'b0}}, rs_abs};
        end else begin
          opnd_reg <= rs_abs;
          acc_reg  <= {{WIDTH{1'b0}}, rt_abs};
        end
      end else if (state_reg == IDLE) begin
        // Moves to HI/LO only when idle and not issuing
        if (mthi) hi_reg <= rs_data;
        if (mtlo) lo_reg <= rs_data;
      end
      if (step_en) begin
        acc_reg <= step_acc;
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (fix_en) begin
        hi_reg   <= fix_hi;
        lo_reg   <= fix_lo;
        done_reg <= 1'b1;
      end
    end
  end

  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard testbench for mips_muldiv: stimulus pushes expected {hi,lo}
// computed from plain 64-bit arithmetic; a monitor pops on each done pulse.
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        mthi, mtlo;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [1:0]  op_q[$];

  always #5 clk = ~clk;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {hi,lo} straight from signed/unsigned 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: if (b == 0) r = {a, 32'hFFFF_FFFF};
             else        r = {32'(sa % sb), 32'(sa / sb)};
      default: if (b == 0) r = {a, 32'hFFFF_FFFF};
               else        r = {a % b, a / b};
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {hi, lo}, 64'hx);
      end else begin
        logic [63:0] e;
        logic [1:0]  o;
        e = exp_q.pop_front();
        o = op_q.pop_front();
        $display("txn op=%0d hi=%h lo=%h exp=%h", o, hi, lo, e);
        chk("result", {hi, lo}, e);
      end
    end
  end

  // Issue one op and follow it to done. intr_cyc >= 0 injects, before that
  // edge, either a second start (kind 0) or an MTHI/MTLO (kind 1).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int intr_cyc, input int intr_kind);
    logic [31:0] hold_hi, hold_lo;
    int lat;
    bit got, held_ok, busy_ok;
    exp_q.push_back(model(op, a, b));
    op_q.push_back(op);
    hold_hi = hi;
    hold_lo = lo;
    md_op = op; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rs_data = $urandom; rt_data = $urandom; md_op = 2'($urandom);
    lat = 0; got = 0; held_ok = 1; busy_ok = 1;
    while (!got && lat < 40) begin
      if (lat == intr_cyc) begin
        if (intr_kind == 0) begin
          start = 1'b1; md_op = 2'b11; rs_data = 32'd9; rt_data = 32'd2;
        end else begin
          mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hDEAD_BEEF;
        end
      end
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      lat++;
      if (done === 1'b1) got = 1;
      else begin
        if ({hi, lo} !== {hold_hi, hold_lo}) held_ok = 0;
        if (busy !== 1'b1) busy_ok = 0;
      end
    end
    chk("latency", 64'(lat), 64'd33);
    chk("hilo_held", 64'(held_ok), 64'd1);
    chk("busy_during", 64'(busy_ok), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h0;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; md_op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0;
    #1;
    chk("reset_state", {hi, lo, 28'b0, busy, done, 2'b0}, 96'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MTHI then MTLO in idle
    mthi = 1'b1; rs_data = 32'h1234_5678;
    @(posedge clk); #1;
    mthi = 1'b0;
    chk("mthi", {hi, lo}, {32'h1234_5678, 32'h0});
    chk("mthi_flags", {busy, done}, 2'b00);
    mtlo = 1'b1; rs_data = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    mtlo = 1'b0;
    chk("mtlo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
    mthi = 1'b1; mtlo = 1'b1; rs_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo", {hi, lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});

    // Directed ops; start alongside mthi must win
    mthi = 1'b1;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 0);
    run_op(2'b11, 32'd100, 32'd0, -1, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, -1, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
    run_op(2'b01, 32'd5, 32'd6, 9, 0);          // second start ignored
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 5, 1); // MTHI/MTLO while busy ignored

    // Reset mid-operation
    md_op = 2'b11; rs_data = 32'd1000; rt_data = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_op", {hi, lo, 30'b0, busy, done}, 96'h0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    chk("no_done_after_rst", 64'(nd), 64'd0);
    run_op(2'b00, 32'd2, 32'd3, -1, 0);

    // Randomized ops, issued back-to-back (start in the done cycle)
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom);
      a = pick_val();
      b = pick_val();
      run_op(op, a, b, -1, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
